// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite responder terminating all five channels into a
// word-addressed register file of NUM_REGS entries.
// Write address and write data are accepted independently, in either order, and
// committed together under the byte strobes. Reads are served one at a time with
// registered data.
// Optional feature macro: AXIL_SLV_DECERR_RESP_EN. When it is defined, out-of-range
// accesses answer SLVERR and out-of-range writes do not pulse reg_wr_pulse_out.
module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                  axi4_lite_clk,
  input  logic                  axi4_lite_rstn,
  input  logic [ADDR_WIDTH-1:0] S_AW_ADDR_IN,
  input  logic                  S_AW_VALID_IN,
  output logic                  S_AW_READY_OUT,
  input  logic [DATA_WIDTH-1:0] S_W_DATA_IN,
  input  logic [STRB_WIDTH-1:0] S_W_STRB_IN,
  input  logic                  S_W_VALID_IN,
  output logic                  S_W_READY_OUT,
  output logic [1:0]            S_B_RESP_OUT,
  output logic                  S_B_VALID_OUT,
  input  logic                  S_B_READY_IN,
  input  logic [ADDR_WIDTH-1:0] S_AR_ADDR_IN,
  input  logic                  S_AR_VALID_IN,
  output logic                  S_AR_READY_OUT,
  output logic [DATA_WIDTH-1:0] S_R_DATA_OUT,
  output logic [1:0]            S_R_RESP_OUT,
  output logic                  S_R_VALID_OUT,
  input  logic                  S_R_READY_IN,
  output logic                  reg_wr_pulse_out,
  output logic [7:0]            reg_wr_index_out
);

  localparam int LSB  = $clog2(STRB_WIDTH);
  localparam int IDXW = ADDR_WIDTH - LSB;
  localparam int RIW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit, so that NUM_REGS == 2**IDXW does not wrap to zero.
  localparam logic [IDXW:0] NREGS_W = (IDXW + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_DATA = 2'd1} rd_state_e;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

  // Write-path state
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  b_valid_q;
  logic [1:0]            b_resp_q;
  logic                  pulse_q;
  logic [7:0]            wr_idx_q;

  // Read-path state
  rd_state_e             rd_state_q;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;

  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_d;
  logic [IDXW-1:0]       wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [RIW-1:0]        wr_ridx, rd_ridx;
  logic [1:0]            b_resp_d, r_resp_d;
  logic                  pulse_d;

  // Readies are gated by the reset input, so they read 0 while reset is held
  // and come back the moment it releases.
  assign S_AW_READY_OUT = axi4_lite_rstn && !aw_held_q && !b_valid_q;
  assign S_W_READY_OUT  = axi4_lite_rstn && !w_held_q && !b_valid_q;
  assign S_AR_READY_OUT = axi4_lite_rstn && (rd_state_q == RD_IDLE);

  assign aw_hs = S_AW_VALID_IN && S_AW_READY_OUT;
  assign w_hs  = S_W_VALID_IN && S_W_READY_OUT;

  // A payload arriving this cycle takes precedence over a held copy.
  // The two can never both be live, because the ready is low while held.
  assign aw_addr_d = aw_hs ? S_AW_ADDR_IN : aw_addr_q;
  assign w_data_d  = w_hs ? S_W_DATA_IN : w_data_q;
  assign w_strb_d  = w_hs ? S_W_STRB_IN : w_strb_q;
  assign commit    = !b_valid_q && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_idx      = IDXW'(aw_addr_d >> LSB);
  assign wr_in_range = {1'b0, wr_idx} < NREGS_W;
  assign wr_ridx     = RIW'(wr_idx);
  assign rd_idx      = IDXW'(S_AR_ADDR_IN >> LSB);
  assign rd_in_range = {1'b0, rd_idx} < NREGS_W;
  assign rd_ridx     = RIW'(rd_idx);

`ifdef AXIL_SLV_DECERR_RESP_EN
  assign b_resp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
  assign r_resp_d = rd_in_range ? RESP_OKAY : RESP_SLVERR;
  assign pulse_d  = wr_in_range;
`else
  assign b_resp_d = RESP_OKAY;
  assign r_resp_d = RESP_OKAY;
  assign pulse_d  = 1'b1;
`endif

  // Write path: capture AW and W, commit under the strobes, and hold B until it is accepted.
  always_ff @(posedge axi4_lite_clk) begin
    if (!axi4_lite_rstn) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      pulse_q   <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= S_AW_ADDR_IN;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= S_W_DATA_IN;
        w_strb_q <= S_W_STRB_IN;
      end
      if (commit) begin
        if (wr_in_range) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb_d[b]) regs_q[wr_ridx][8*b +: 8] <= w_data_d[8*b +: 8];
          end
        end
        b_valid_q <= 1'b1;
        b_resp_q  <= b_resp_d;
        pulse_q   <= pulse_d;
        wr_idx_q  <= 8'(wr_idx);
      end
      if (b_valid_q && S_B_READY_IN) begin
        b_valid_q <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  // Read FSM: latch the data on the AR handshake and hold R until it is accepted.
  // The read samples regs_q before any write lands on the same edge.
  always_ff @(posedge axi4_lite_clk) begin
    if (!axi4_lite_rstn) begin
      rd_state_q <= RD_IDLE;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (S_AR_VALID_IN) begin
            r_data_q   <= rd_in_range ? regs_q[rd_ridx] : '0;
            r_resp_q   <= r_resp_d;
            r_valid_q  <= 1'b1;
            rd_state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (S_R_READY_IN) begin
            r_valid_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: begin
          r_valid_q  <= 1'b0;
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

  assign S_B_VALID_OUT    = b_valid_q;
  assign S_B_RESP_OUT     = b_resp_q;
  assign S_R_VALID_OUT    = r_valid_q;
  assign S_R_DATA_OUT     = r_data_q;
  assign S_R_RESP_OUT     = r_resp_q;
  assign reg_wr_pulse_out = pulse_q;
  assign reg_wr_index_out = wr_idx_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs.
// Table-driven write/read vectors, plus hand-written sequences for the staggered
// handshake, same-edge read/write, backpressure and reset-in-flight cases.
module tb_axi4_lite_slave_regs;

  localparam logic [1:0] OK = 2'b00;
`ifdef AXIL_SLV_DECERR_RESP_EN
  localparam logic [1:0] OOR_RESP  = 2'b10;
  localparam bit         OOR_PULSE = 1'b0;
`else
  localparam logic [1:0] OOR_RESP  = 2'b00;
  localparam bit         OOR_PULSE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
  logic [3:0]  w_strb = '0;
  logic        aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, pulse;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  logic [7:0]  wr_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_regs dut (
    .axi4_lite_clk(clk), .axi4_lite_rstn(rstn),
    .S_AW_ADDR_IN(aw_addr), .S_AW_VALID_IN(aw_valid), .S_AW_READY_OUT(aw_ready),
    .S_W_DATA_IN(w_data), .S_W_STRB_IN(w_strb), .S_W_VALID_IN(w_valid), .S_W_READY_OUT(w_ready),
    .S_B_RESP_OUT(b_resp), .S_B_VALID_OUT(b_valid), .S_B_READY_IN(b_ready),
    .S_AR_ADDR_IN(ar_addr), .S_AR_VALID_IN(ar_valid), .S_AR_READY_OUT(ar_ready),
    .S_R_DATA_OUT(r_data), .S_R_RESP_OUT(r_resp), .S_R_VALID_OUT(r_valid), .S_R_READY_IN(r_ready),
    .reg_wr_pulse_out(pulse), .reg_wr_index_out(wr_index)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented in the same cycle with BREADY=1. Returns the response,
  // the pulse and index seen with BVALID, and the latency after the last handshake.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic pls, output logic [7:0] idx,
                           output int lat);
    int  since = 0;
    bit  hs_aw, hs_w, got = 0;
    aw_addr = a; w_data = d; w_strb = s;
    aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
    resp = 2'bxx; pls = 1'bx; idx = 8'hxx; lat = -1;
    for (int c = 0; c < 20 && !got; c++) begin
      hs_aw = aw_valid && aw_ready;
      hs_w  = w_valid && w_ready;
      tick();
      if (hs_aw) aw_valid = 1'b0;
      if (hs_w)  w_valid = 1'b0;
      if (!aw_valid && !w_valid) since++;
      if (b_valid) begin
        resp = b_resp; pls = pulse; idx = wr_index; lat = since; got = 1;
      end
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("wr_bvalid_seen", 40'(got), 40'd1);
    tick();
    chk("wr_b_done_pulse_low", {38'd0, b_valid, pulse}, 40'd0);
  endtask

  // AR with RREADY=1. Returns the data and response seen with RVALID, and the latency.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int  since = 0;
    bit  hs, got = 0;
    ar_addr = a; ar_valid = 1'b1; r_ready = 1'b1;
    d = 'x; resp = 2'bxx; lat = -1;
    for (int c = 0; c < 20 && !got; c++) begin
      hs = ar_valid && ar_ready;
      tick();
      if (hs) ar_valid = 1'b0;
      if (!ar_valid) since++;
      if (r_valid) begin
        d = r_data; resp = r_resp; lat = since; got = 1;
      end
    end
    ar_valid = 1'b0;
    chk("rd_rvalid_seen", 40'(got), 40'd1);
    tick();
    chk("rd_r_done", {38'd0, r_valid, ar_ready}, 40'd1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    bit          pulse;
    logic [7:0]  idx;
  } vec_t;

  vec_t tv[13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [7:0]  idx;
    logic        pls;
    int          lat;

    // Table: write rows check B/pulse/index, read rows check R data (in .data)/resp.
    tv[0]  = '{1, 32'h08, 32'hDEADBEEF, 4'hF, OK, 1, 8'd2};
    tv[1]  = '{0, 32'h08, 32'hDEADBEEF, 4'h0, OK, 0, 8'd0};
    tv[2]  = '{1, 32'h0C, 32'hAABBCCDD, 4'b0101, OK, 1, 8'd3};
    tv[3]  = '{0, 32'h0C, 32'h11BB33DD, 4'h0, OK, 0, 8'd0};
    tv[4]  = '{1, 32'h04, 32'h12345678, 4'h0, OK, 1, 8'd1};
    tv[5]  = '{0, 32'h04, 32'h00000000, 4'h0, OK, 0, 8'd0};
    tv[6]  = '{1, 32'h43, 32'hFFFFFFFF, 4'hF, OOR_RESP, OOR_PULSE, 8'd16};
    tv[7]  = '{0, 32'h40, 32'h00000000, 4'h0, OOR_RESP, 0, 8'd0};
    tv[8]  = '{0, 32'h08, 32'hDEADBEEF, 4'h0, OK, 0, 8'd0};
    tv[9]  = '{0, 32'h0C, 32'h11BB33DD, 4'h0, OK, 0, 8'd0};
    tv[10] = '{1, 32'h3D, 32'hCAFEF00D, 4'hF, OK, 1, 8'd15};
    tv[11] = '{0, 32'h3C, 32'hCAFEF00D, 4'h0, OK, 0, 8'd0};
    tv[12] = '{0, 32'h00, 32'h00000000, 4'h0, OK, 0, 8'd0};

    // Reset state
    repeat (2) tick();
    chk("rst_readies_low", {37'd0, aw_ready, w_ready, ar_ready}, 40'd0);
    chk("rst_outputs", {3'd0, b_valid, b_resp, r_valid, r_resp, pulse, wr_index, r_data}, 40'd0);
    rstn = 1'b1;
    #1;
    chk("rst_release_readies", {37'd0, aw_ready, w_ready, ar_ready}, 40'd7);

    // W three cycles ahead of AW
    w_data = 32'h11223344; w_strb = 4'hF; w_valid = 1'b1; b_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    chk("stag_wready_low", {38'd0, w_ready, aw_ready}, 40'd1);
    repeat (2) begin
      tick();
      chk("stag_no_bvalid", 40'(b_valid), 40'd0);
    end
    aw_addr = 32'h0C; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0;
    chk("stag_b", {29'd0, b_valid, b_resp, pulse, wr_index}, {29'd0, 1'b1, OK, 1'b1, 8'd3});
    tick();
    chk("stag_b_done", {36'd0, b_valid, pulse, aw_ready, w_ready}, 40'd3);
    axi_read(32'h0C, d, resp, lat);
    chk("stag_rdata", {6'd0, resp, d}, {6'd0, OK, 32'h11223344});

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      if (tv[i].is_wr) begin
        axi_write(tv[i].addr, tv[i].data, tv[i].strb, resp, pls, idx, lat);
        chk($sformatf("tv%0d_bresp", i), 40'(resp), 40'(tv[i].resp));
        chk($sformatf("tv%0d_pulse", i), 40'(pls), 40'(tv[i].pulse));
        if (tv[i].pulse) chk($sformatf("tv%0d_index", i), 40'(idx), 40'(tv[i].idx));
        chk($sformatf("tv%0d_wlat", i), 40'(lat), 40'd1);
      end else begin
        axi_read(tv[i].addr, d, resp, lat);
        chk($sformatf("tv%0d_rdata", i), 40'(d), 40'(tv[i].data));
        chk($sformatf("tv%0d_rresp", i), 40'(resp), 40'(tv[i].resp));
        chk($sformatf("tv%0d_rlat", i), 40'(lat), 40'd1);
      end
    end

    // Read and write to the same register on one edge: read sees the old value
    axi_write(32'h14, 32'h55555555, 4'hF, resp, pls, idx, lat);
    ar_addr = 32'h14; ar_valid = 1'b1; r_ready = 1'b1;
    aw_addr = 32'h14; aw_valid = 1'b1; w_data = 32'h66666666; w_strb = 4'hF; w_valid = 1'b1;
    b_ready = 1'b1;
    tick();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    chk("same_edge_rdata", {6'd0, b_valid, r_valid, r_data}, {6'd0, 2'b11, 32'h55555555});
    tick();
    axi_read(32'h14, d, resp, lat);
    chk("same_edge_after", 40'(d), 40'h66666666);

    // B backpressure
    aw_addr = 32'h18; w_data = 32'h77777777; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_b_hold", {35'd0, b_valid, b_resp, aw_ready, w_ready}, {35'd0, 1'b1, OK, 2'b00});
      tick();
    end
    b_ready = 1'b1;
    tick();
    chk("bp_b_release", {37'd0, b_valid, aw_ready, w_ready}, 40'd3);

    // R backpressure
    ar_addr = 32'h18; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    ar_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_r_hold", {4'd0, r_valid, ar_ready, r_resp, r_data}, {4'd0, 2'b10, OK, 32'h77777777});
      tick();
    end
    r_ready = 1'b1;
    tick();
    chk("bp_r_release", {38'd0, r_valid, ar_ready}, 40'd1);

    // Reset with BVALID and RVALID both pending
    aw_addr = 32'h1C; w_data = 32'h88888888; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
    ar_addr = 32'h08; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    chk("inflight_valids", {38'd0, b_valid, r_valid}, 40'd3);
    rstn = 1'b0;
    tick();
    chk("inflight_rst", {34'd0, b_valid, r_valid, pulse, aw_ready, w_ready, ar_ready}, 40'd0);
    rstn = 1'b1;
    #1;
    chk("inflight_release", {37'd0, aw_ready, w_ready, ar_ready}, 40'd7);
    axi_read(32'h08, d, resp, lat);
    chk("post_rst_reg2", 40'(d), 40'd0);
    axi_read(32'h0C, d, resp, lat);
    chk("post_rst_reg3", 40'(d), 40'd0);
    axi_read(32'h1C, d, resp, lat);
    chk("post_rst_reg7", 40'(d), 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-Lite responder that answers the transactions our AXI4-Lite master issues.
- Terminates all five channels into an internal word-addressed register file of NUM_REGS entries.
- Accepts write address and write data independently, in either order; commits on byte strobes; returns OKAY/SLVERR.
- Serves one read at a time with registered data.

Parameters:
- ADDR_WIDTH, 32, AW/AR address width.
- DATA_WIDTH, 32, register and data bus width (multiple of 8).
- STRB_WIDTH, 4, DATA_WIDTH/8.
- NUM_REGS, 16, number of registers, at most 2^(ADDR_WIDTH-log2(STRB_WIDTH)).

Ports:
- axi4_lite_clk  in  1  system clock, all logic on rising edge.
- axi4_lite_rstn  in  1  synchronous, active-low reset, sampled on the rising edge of axi4_lite_clk.
- S_AW_ADDR_IN  in  ADDR_WIDTH  write address.
- S_AW_VALID_IN  in  1  write address valid.
- S_AW_READY_OUT  out  1  write address ready.
- S_W_DATA_IN  in  DATA_WIDTH  write data.
- S_W_STRB_IN  in  STRB_WIDTH  byte enables.
- S_W_VALID_IN  in  1  write data valid.
- S_W_READY_OUT  out  1  write data ready.
- S_B_RESP_OUT  out  2  write response.
- S_B_VALID_OUT  out  1  write response valid.
- S_B_READY_IN  in  1  write response ready.
- S_AR_ADDR_IN  in  ADDR_WIDTH  read address.
- S_AR_VALID_IN  in  1  read address valid.
- S_AR_READY_OUT  out  1  read address ready.
- S_R_DATA_OUT  out  DATA_WIDTH  read data.
- S_R_RESP_OUT  out  2  read response.
- S_R_VALID_OUT  out  1  read data valid.
- S_R_READY_IN  in  1  read data ready.
- reg_wr_pulse_out  out  1  one-cycle pulse when a register is committed.
- reg_wr_index_out  out  8  index of the committed register; valid with the pulse.

Behaviour:
- Reset (axi4_lite_rstn=0 at a clock edge):
  - All registers, captured address/data, flags, S_B_*, S_R_*, reg_wr_pulse_out and reg_wr_index_out go to 0.
  - Ready outputs go to 0 during reset.
  - The first cycle after reset releases, AWREADY, WREADY and ARREADY are 1.
  - An in-flight transaction is abandoned; no response is issued for it.
- Address decode:
  - index = addr >> log2(STRB_WIDTH); low byte-offset bits are ignored.
  - Address is in range iff index < NUM_REGS.
- Write path, flags aw_held and w_held:
  - S_AW_READY_OUT = !aw_held && !S_B_VALID_OUT.
  - S_W_READY_OUT = !w_held && !S_B_VALID_OUT.
  - Each handshake captures its payload and sets its flag.
  - On the edge where both payloads become available (same cycle or staggered, either order):
    - Each byte lane i with STRB[i]=1 is written; lanes with STRB=0 keep their value.
    - S_B_VALID_OUT<=1 with S_B_RESP_OUT; reg_wr_pulse_out<=1 for one cycle.
    - Minimum latency: BVALID asserted one cycle after the final handshake.
  - BVALID and BRESP are held stable until S_B_READY_IN=1. On that handshake edge, BVALID and both flags clear; the next transaction can be accepted in the following cycle.
  - STRB=0 is a legal no-op write: response OKAY, pulse still fires.
- Read path FSM:
  - RD_IDLE: S_AR_READY_OUT=1. On AR handshake, latch S_R_DATA_OUT (or 0 if out of range) and S_R_RESP_OUT; go to RD_DATA.
  - RD_DATA: S_AR_READY_OUT=0, S_R_VALID_OUT=1, data and response stable. On S_R_READY_IN=1, go to RD_IDLE and clear S_R_VALID_OUT.
  - Any other state encoding recovers to RD_IDLE.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the pre-write value.
  - Read and write paths are otherwise fully independent.
- Response codes: OKAY=2'b00; SLVERR=2'b10 (only per the optional feature below).
- Out-of-range writes never modify any register.

Optional Feature:
- Macro: AXIL_SLV_DECERR_RESP_EN.
- Defined:
  - Out-of-range writes and reads return SLVERR (2'b10).
  - Out-of-range reads return data 0.
  - Out-of-range writes do not pulse reg_wr_pulse_out.
- Undefined:
  - Out-of-range accesses return OKAY.
  - Reads return 0; writes are silently dropped; the pulse still fires with the truncated index.

Test Plan:
- Reset, then AW=0x08 and W=0xDEADBEEF, STRB=4'hF, in the same cycle, BREADY=1 -> BVALID next cycle, BRESP=00, reg_wr_pulse_out with index 2. Then AR=0x08 -> RVALID one cycle after the handshake, RDATA=0xDEADBEEF, RRESP=00.
- W sent 3 cycles before AW (addr 0x0C, data 0x11223344) -> WREADY low after capture, BVALID one cycle after AW handshake. Read back 0x11223344.
- Partial strobe: write 0xAABBCCDD with STRB=4'b0101 over register value 0x11223344 -> readback 0x11BB33DD.
- Backpressure: BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout. RREADY=0 for 4 cycles -> RDATA stable, ARREADY=0.
- Out-of-range AR/AW at 0x40 (NUM_REGS=16) -> with macro: RRESP=BRESP=10, RDATA=0, no registers changed. Without macro: responses 00, no registers changed.
- Reset asserted while BVALID=1 and RVALID=1 -> both valids 0 after the reset edge, all registers read 0, and ready outputs return to 1 the first cycle after reset releases.
